// File: rtl/event_trace_arbiter.sv
// event_trace_arbiter
// Gathers rising/falling edge pulses from NUM_CH edge-detector channels,
// timestamps each one into a one-deep per-channel slot, and serialises the
// pending slots round-robin onto a single valid/ready trace stream.
// Output word layout: {timestamp, channel id (6 bits), rise, fall}.
module event_trace_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int TS_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [NUM_CH-1:0]     rise_evt_i,
  input  logic [NUM_CH-1:0]     fall_evt_i,
  output logic [TS_WIDTH+7:0]   m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [NUM_CH-1:0]     pending_o,
  output logic [15:0]           drop_count_o
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Output-side state
  state_e                state_q, state_d;
  logic [TS_WIDTH+7:0]   tdata_q, tdata_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  // Free-running timestamp and drop statistics
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  // Per-channel one-deep event slots
  logic [TS_WIDTH-1:0]   slot_ts_q [NUM_CH];
  logic [TS_WIDTH-1:0]   slot_ts_d [NUM_CH];
  logic [NUM_CH-1:0]     slot_rise_q, slot_rise_d;
  logic [NUM_CH-1:0]     slot_fall_q, slot_fall_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;

  // Arbitration and capture helpers
  logic                  load_ok;
  logic                  grant_fire;
  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [5:0]            grant_ch;
  logic [NUM_CH-1:0]     slot_freed;
  logic [NUM_CH-1:0]     has_evt;
  logic                  drop_any;

  assign has_evt      = rise_evt_i | fall_evt_i;
  assign m_tvalid_o   = (state_q == SEND);
  assign m_tdata_o    = tdata_q;
  assign pending_o    = pending_q;
  assign drop_count_o = drop_cnt_q;

  // The output register may take a new word when it is empty or its word is leaving now
  assign load_ok    = (state_q == IDLE) || m_tready_i;
  assign grant_fire = load_ok && grant_found;
  assign grant_ch   = 6'(grant_idx);

  // Round-robin search: first pending channel at or after the rotating pointer
  always_comb begin
    int scan_idx;
    logic [PTR_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    cand        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_CH) begin
        scan_idx = scan_idx - NUM_CH;
      end
      cand = PTR_W'(scan_idx);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot of the slot being drained into the output register this cycle
  always_comb begin
    slot_freed = '0;
    if (grant_fire) begin
      slot_freed[grant_idx] = 1'b1;
    end
  end

  // Slot capture: a slot being drained this cycle can accept a new event without a drop
  always_comb begin
    slot_ts_d   = slot_ts_q;
    slot_rise_d = slot_rise_q;
    slot_fall_d = slot_fall_q;
    pending_d   = pending_q;
    drop_any    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot_freed[i]) begin
        pending_d[i] = 1'b0;
      end
      if (enable_i && has_evt[i]) begin
        if (!pending_q[i] || slot_freed[i]) begin
          slot_ts_d[i]   = ts_q;
          slot_rise_d[i] = rise_evt_i[i];
          slot_fall_d[i] = fall_evt_i[i];
          pending_d[i]   = 1'b1;
        end else begin
          drop_any = 1'b1;
        end
      end
    end
  end

  // Timestamp advances only while capturing; drop counter counts cycles and sticks at max
  always_comb begin
    ts_d       = enable_i ? (ts_q + TS_WIDTH'(1)) : ts_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_any && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // IDLE/SEND next state, output word load and round-robin pointer update
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_fire) begin
      state_d  = SEND;
      tdata_d  = {slot_ts_q[grant_idx], grant_ch,
                  slot_rise_q[grant_idx], slot_fall_q[grant_idx]};
      rr_ptr_d = (grant_idx == LAST_CH) ? '0 : (grant_idx + PTR_ONE);
    end else if ((state_q == SEND) && m_tready_i) begin
      state_d = IDLE;
    end
  end

  // Output FSM state register; reset discards any word in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tdata_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Timestamp and drop counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Per-channel slot registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        slot_ts_q[i] <= '0;
      end
      slot_rise_q <= '0;
      slot_fall_q <= '0;
      pending_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        slot_ts_q[i] <= slot_ts_d[i];
      end
      slot_rise_q <= slot_rise_d;
      slot_fall_q <= slot_fall_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_event_trace_arbiter.sv
// Self-checking bench for event_trace_arbiter (4 channels, 8-bit timestamp).
// Expected trace words are queued when events are driven and compared in
// order as the DUT hands them off on the output stream.
module tb_event_trace_arbiter;

  localparam int NUM_CH = 4;
  localparam int TS_W   = 8;
  localparam int DW     = TS_W + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [3:0]    riseEvt = '0;
  logic [3:0]    fallEvt = '0;
  logic          mTready = 1'b0;
  logic [DW-1:0] mTdata;
  logic          mTvalid;
  logic [3:0]    pending;
  logic [15:0]   dropCount;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] expQ [$];
  logic [DW-1:0] expWord;
  logic [TS_W-1:0] tbTs;

  event_trace_arbiter #(
    .NUM_CH  (NUM_CH),
    .TS_WIDTH(TS_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .rise_evt_i  (riseEvt),
    .fall_evt_i  (fallEvt),
    .m_tdata_o   (mTdata),
    .m_tvalid_o  (mTvalid),
    .m_tready_i  (mTready),
    .pending_o   (pending),
    .drop_count_o(dropCount)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT should stamp on events in the current cycle
  always @(posedge clk) begin
    if (rst) tbTs <= '0;
    else if (enable) tbTs <= tbTs + 8'd1;
  end

  // Scoreboard: every accepted word must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && mTvalid && mTready) begin
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_word got=%h required=none", mTdata);
      end else begin
        expWord = expQ.pop_front();
        if (mTdata !== expWord) begin
          testsFailed++;
          $display("[TB] FAIL trace_word got=%h required=%h", mTdata, expWord);
        end
      end
    end
  end

  // Absolute time limit so the run always ends
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    enable = 1'b0;
    riseEvt = '0;
    fallEvt = '0;
    mTready = 1'b0;
    tick();
    tick();
    expQ.delete();
    rst = 1'b0;
  endtask

  task automatic pushWord(input logic [TS_W-1:0] ts, input int ch, input logic r, input logic f);
    expQ.push_back({ts, 6'(ch), r, f});
  endtask

  // Run until every expected word has been accepted and the stream is idle
  task automatic waitDrain(input int budget, input string name);
    int n = 0;
    while ((expQ.size() != 0 || mTvalid) && n < budget) begin
      tick();
      n++;
    end
    testsRun++;
    if (expQ.size() != 0 || mTvalid) begin
      testsFailed++;
      $display("[TB] FAIL drain_%s got=%0d_left required=0_left", name, expQ.size());
    end
  endtask

  task automatic waitTs(input logic [TS_W-1:0] target);
    int n = 0;
    while (tbTs != target && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    testsRun += 4;
    if (mTvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got=%b required=0", mTvalid); end
    if (pending !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_pending got=%h required=0", pending); end
    if (dropCount !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_drop got=%h required=0", dropCount); end
    if (mTdata !== '0) begin testsFailed++; $display("[TB] FAIL reset_tdata got=%h required=0", mTdata); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    applyReset();
    enable = 1'b1;
    mTready = 1'b1;
    waitTs(8'd5);
    riseEvt = 4'b0100;
    pushWord(8'd5, 2, 1'b1, 1'b0);
    tick();
    riseEvt = '0;
    testsRun += 2;
    if (mTvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_n1_valid got=%b required=0", mTvalid); end
    if (pending !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_n1_pending got=%b required=0100", pending); end
    tick();
    testsRun += 2;
    if (mTvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_n2_valid got=%b required=1", mTvalid); end
    if (pending !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_n2_pending got=%b required=0000", pending); end
    tick();
    testsRun += 2;
    if (mTvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_n3_valid got=%b required=0", mTvalid); end
    if (pending !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_n3_pending got=%b required=0000", pending); end
    waitDrain(20, "single");
  endtask

  task automatic test_round_robin();
    applyReset();
    enable = 1'b1;
    mTready = 1'b1;
    tick();
    tick();
    riseEvt = 4'b1111;
    for (int ch = 0; ch < NUM_CH; ch++) pushWord(tbTs, ch, 1'b1, 1'b0);
    tick();
    riseEvt = '0;
    tick();
    for (int k = 0; k < NUM_CH; k++) begin
      testsRun++;
      if (mTvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rr_stream_valid_%0d got=%b required=1", k, mTvalid); end
      tick();
    end
    waitDrain(20, "round_robin");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] heldExp;
    applyReset();
    enable = 1'b1;
    mTready = 1'b0;
    tick();
    riseEvt = 4'b0010;
    pushWord(tbTs, 1, 1'b1, 1'b0);
    heldExp = {tbTs, 6'd1, 1'b1, 1'b0};
    tick();
    riseEvt = '0;
    tick();
    testsRun += 2;
    if (mTvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_valid got=%b required=1", mTvalid); end
    if (mTdata !== heldExp) begin testsFailed++; $display("[TB] FAIL bp_first_word got=%h required=%h", mTdata, heldExp); end
    riseEvt = 4'b0010;
    pushWord(tbTs, 1, 1'b1, 1'b0);
    tick();
    riseEvt = '0;
    tick();
    riseEvt = 4'b0010;
    tick();
    riseEvt = '0;
    testsRun += 4;
    if (dropCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL bp_drop got=%0d required=1", dropCount); end
    if (mTdata !== heldExp) begin testsFailed++; $display("[TB] FAIL bp_held_word got=%h required=%h", mTdata, heldExp); end
    if (mTvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_held_valid got=%b required=1", mTvalid); end
    if (pending !== 4'b0010) begin testsFailed++; $display("[TB] FAIL bp_pending got=%b required=0010", pending); end
    mTready = 1'b1;
    waitDrain(20, "backpressure");
    testsRun++;
    if (dropCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL bp_drop_after got=%0d required=1", dropCount); end
  endtask

  task automatic test_back_to_back();
    applyReset();
    enable = 1'b1;
    mTready = 1'b1;
    tick();
    riseEvt = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      pushWord(tbTs, 0, 1'b1, 1'b0);
      tick();
    end
    riseEvt = '0;
    waitDrain(30, "back_to_back");
    testsRun++;
    if (dropCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL b2b_no_drop got=%0d required=0", dropCount); end
  endtask

  task automatic test_wrap();
    applyReset();
    enable = 1'b1;
    mTready = 1'b1;
    waitTs(8'd255);
    riseEvt = 4'b0001;
    pushWord(8'd255, 0, 1'b1, 1'b0);
    tick();
    riseEvt = 4'b0010;
    pushWord(8'd0, 1, 1'b1, 1'b0);
    tick();
    riseEvt = '0;
    waitDrain(20, "wrap");
  endtask

  task automatic test_rise_fall_and_reset();
    applyReset();
    enable = 1'b1;
    mTready = 1'b1;
    tick();
    riseEvt = 4'b1000;
    fallEvt = 4'b1000;
    pushWord(tbTs, 3, 1'b1, 1'b1);
    tick();
    riseEvt = '0;
    fallEvt = '0;
    waitDrain(20, "rise_fall");
    mTready = 1'b0;
    riseEvt = 4'b0001;
    tick();
    riseEvt = '0;
    tick();
    riseEvt = 4'b0001;
    tick();
    riseEvt = '0;
    tick();
    riseEvt = 4'b0001;
    tick();
    riseEvt = '0;
    tick();
    testsRun += 3;
    if (mTvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL pre_rst_valid got=%b required=1", mTvalid); end
    if (pending !== 4'b0001) begin testsFailed++; $display("[TB] FAIL pre_rst_pending got=%b required=0001", pending); end
    if (dropCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL pre_rst_drop got=%0d required=1", dropCount); end
    rst = 1'b1;
    tick();
    testsRun += 3;
    if (mTvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_rst_valid got=%b required=0", mTvalid); end
    if (pending !== 4'b0000) begin testsFailed++; $display("[TB] FAIL mid_rst_pending got=%b required=0000", pending); end
    if (dropCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL mid_rst_drop got=%0d required=0", dropCount); end
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic test_drop_saturation();
    applyReset();
    enable = 1'b1;
    mTready = 1'b0;
    tick();
    riseEvt = 4'b0001;
    repeat (10) tick();
    testsRun++;
    if (dropCount !== 16'd8) begin testsFailed++; $display("[TB] FAIL drop_count_8 got=%0d required=8", dropCount); end
    enable = 1'b0;
    repeat (5) tick();
    testsRun++;
    if (dropCount !== 16'd8) begin testsFailed++; $display("[TB] FAIL drop_disabled got=%0d required=8", dropCount); end
    enable = 1'b1;
    repeat (70000) tick();
    riseEvt = '0;
    testsRun++;
    if (dropCount !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL drop_saturate got=%h required=ffff", dropCount); end
    applyReset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_rise_fall_and_reset();
    test_drop_saturation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
